// File: rtl/dpsram_arbiter.sv
// ----------------------------------------------------------------------------
// dpsram_arbiter
//
// Sits in front of a single dual-port SRAM (one write port, one read port)
// and shares each port between two clients with round-robin arbitration.
// The SRAM cannot read and write the same address in the same cycle.
// When that would happen, the write wins. The blocked read address is
// then protected for one cycle, so the read is guaranteed to issue next.
// Read data returns one cycle after issue, tagged with the client id.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   wrK_valid/ready          write handshake, ready is combinational
//   wrK_addr/data/mask       write address, data, per-bit enable (1 = write)
//   rdK_valid/ready          read handshake, ready is combinational
//   rdK_addr                 read address
//   rsp_valid/id             registered read-response valid and client id
//   rsp_data                 read data, straight from sram_q
//   sram_web/aa/d/bweb       SRAM write port (web=1 writes, bweb bit 1 = write)
//   sram_reb/ab              SRAM read port (reb=1 reads)
//   sram_q                   SRAM read data (one cycle after sram_reb)
// ----------------------------------------------------------------------------
module dpsram_arbiter #(
   parameter int BITWIDTH = 32,
   parameter int DEPTH    = 8
) (
   input  logic                CLK,
   input  logic                RST,

   input  logic                wr0_valid,
   output logic                wr0_ready,
   input  logic [DEPTH-1:0]    wr0_addr,
   input  logic [BITWIDTH-1:0] wr0_data,
   input  logic [BITWIDTH-1:0] wr0_mask,

   input  logic                wr1_valid,
   output logic                wr1_ready,
   input  logic [DEPTH-1:0]    wr1_addr,
   input  logic [BITWIDTH-1:0] wr1_data,
   input  logic [BITWIDTH-1:0] wr1_mask,

   input  logic                rd0_valid,
   output logic                rd0_ready,
   input  logic [DEPTH-1:0]    rd0_addr,

   input  logic                rd1_valid,
   output logic                rd1_ready,
   input  logic [DEPTH-1:0]    rd1_addr,

   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [BITWIDTH-1:0] rsp_data,

   output logic                sram_web,
   output logic [DEPTH-1:0]    sram_aa,
   output logic [BITWIDTH-1:0] sram_d,
   output logic [BITWIDTH-1:0] sram_bweb,
   output logic                sram_reb,
   output logic [DEPTH-1:0]    sram_ab,
   input  logic [BITWIDTH-1:0] sram_q
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic             wr_ptr_q,    wr_ptr_d;
   logic             rd_ptr_q,    rd_ptr_d;
   logic             rd_prio_q,   rd_prio_d;
   logic [DEPTH-1:0] prio_addr_q, prio_addr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q,    rsp_id_d;

   // -------------------------------------------------------------------------
   // Write arbitration
   // -------------------------------------------------------------------------
   logic                wr0_elig;
   logic                wr1_elig;
   logic                wr_gnt;
   logic                wr_gnt_id;
   logic [DEPTH-1:0]    wr_addr;
   logic [BITWIDTH-1:0] wr_data;
   logic [BITWIDTH-1:0] wr_mask;

   always_comb begin
      // Requests are ignored entirely while reset is held.
      wr0_elig = wr0_valid & ~RST;
      wr1_elig = wr1_valid & ~RST;

      // A read that lost a conflict last cycle owns prio_addr for this
      // cycle; writers to that address are held off so the read can go.
      if (rd_prio_q && (wr0_addr == prio_addr_q)) begin
         wr0_elig = 1'b0;
      end
      if (rd_prio_q && (wr1_addr == prio_addr_q)) begin
         wr1_elig = 1'b0;
      end

      wr_gnt    = wr0_elig | wr1_elig;
      wr_gnt_id = (wr0_elig & wr1_elig) ? wr_ptr_q : wr1_elig;

      wr_addr = '0;
      wr_data = '0;
      wr_mask = '0;
      if (wr_gnt) begin
         if (wr_gnt_id) begin
            wr_addr = wr1_addr;
            wr_data = wr1_data;
            wr_mask = wr1_mask;
         end else begin
            wr_addr = wr0_addr;
            wr_data = wr0_data;
            wr_mask = wr0_mask;
         end
      end
   end

   assign wr0_ready = wr_gnt & ~wr_gnt_id;
   assign wr1_ready = wr_gnt &  wr_gnt_id;
   assign sram_web  = wr_gnt;
   assign sram_aa   = wr_addr;
   assign sram_d    = wr_data;
   assign sram_bweb = wr_mask;

   // -------------------------------------------------------------------------
   // Read arbitration
   // -------------------------------------------------------------------------
   logic             rd0_act;
   logic             rd1_act;
   logic             rd_cand;
   logic             rd_cand_id;
   logic [DEPTH-1:0] rd_cand_addr;
   logic             rd_conflict;
   logic             rd_issue;

   always_comb begin
      rd0_act = rd0_valid & ~RST;
      rd1_act = rd1_valid & ~RST;

      rd_cand      = rd0_act | rd1_act;
      rd_cand_id   = (rd0_act & rd1_act) ? rd_ptr_q : rd1_act;
      rd_cand_addr = rd_cand_id ? rd1_addr : rd0_addr;

      // Same-cycle read/write of one address is illegal for the macro;
      // the write already won, so the read backs off this cycle.
      rd_conflict = rd_cand & wr_gnt & (rd_cand_addr == wr_addr);
      rd_issue    = rd_cand & ~rd_conflict;
   end

   assign rd0_ready = rd_issue & ~rd_cand_id;
   assign rd1_ready = rd_issue &  rd_cand_id;
   assign sram_reb  = rd_issue;
   assign sram_ab   = rd_issue ? rd_cand_addr : '0;

   // -------------------------------------------------------------------------
   // Next state
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_prio_d   = rd_prio_q;
      prio_addr_d = prio_addr_q;
      rsp_valid_d = rd_issue;
      rsp_id_d    = rsp_id_q;

      if (wr_gnt) begin
         wr_ptr_d = ~wr_gnt_id;
      end

      if (rd_issue) begin
         rd_ptr_d  = ~rd_cand_id;
         rsp_id_d  = rd_cand_id;
         rd_prio_d = 1'b0;
      end else if (rd_conflict) begin
         rd_prio_d   = 1'b1;
         prio_addr_d = rd_cand_addr;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         rd_prio_q   <= 1'b0;
         prio_addr_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_prio_q   <= rd_prio_d;
         prio_addr_q <= prio_addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   // -------------------------------------------------------------------------
   // Response path
   // -------------------------------------------------------------------------
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = sram_q;

endmodule

// File: tb/tb_dpsram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dpsram_arbiter
//
// Directed bench for dpsram_arbiter with a behavioural dual-port SRAM model
// (masked write, registered read). Each scenario task drives stimulus and
// checks the arbiter outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_dpsram_arbiter;

   localparam int BW = 32;
   localparam int DW = 8;

   logic          CLK;
   logic          RST;
   logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
   logic [DW-1:0] wr0_addr, wr1_addr;
   logic [BW-1:0] wr0_data, wr1_data, wr0_mask, wr1_mask;
   logic          rd0_valid, rd0_ready, rd1_valid, rd1_ready;
   logic [DW-1:0] rd0_addr, rd1_addr;
   logic          rsp_valid, rsp_id;
   logic [BW-1:0] rsp_data;
   logic          sram_web, sram_reb;
   logic [DW-1:0] sram_aa, sram_ab;
   logic [BW-1:0] sram_d, sram_bweb, sram_q;

   int n_chk;
   int n_fail;

   dpsram_arbiter #(.BITWIDTH(BW), .DEPTH(DW)) dut (
      .CLK(CLK), .RST(RST),
      .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
      .wr0_data(wr0_data), .wr0_mask(wr0_mask),
      .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
      .wr1_data(wr1_data), .wr1_mask(wr1_mask),
      .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
      .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .sram_web(sram_web), .sram_aa(sram_aa), .sram_d(sram_d),
      .sram_bweb(sram_bweb), .sram_reb(sram_reb), .sram_ab(sram_ab),
      .sram_q(sram_q)
   );

   // Behavioural SRAM: masked write and registered read on the same edge.
   logic [BW-1:0] mem [0:(1<<DW)-1];

   always @(posedge CLK) begin
      if (sram_web) mem[sram_aa] <= (mem[sram_aa] & ~sram_bweb) | (sram_d & sram_bweb);
      if (sram_reb) sram_q <= mem[sram_ab];
   end

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive point: 2 time units after the rising edge.
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_inputs();
      wr0_valid = 0; wr0_addr = '0; wr0_data = '0; wr0_mask = '0;
      wr1_valid = 0; wr1_addr = '0; wr1_data = '0; wr1_mask = '0;
      rd0_valid = 0; rd0_addr = '0;
      rd1_valid = 0; rd1_addr = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      clear_inputs();
      RST = 1'b1;
      wr0_valid = 1; wr0_addr = 8'd3; wr1_valid = 1; wr1_addr = 8'd4;
      rd0_valid = 1; rd0_addr = 8'd1; rd1_valid = 1; rd1_addr = 8'd2;
      #1;
      n_chk++;
      if ({wr0_ready, wr1_ready, rd0_ready, rd1_ready, sram_web, sram_reb, rsp_valid} !== 7'b0) begin
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {wr0_ready, wr1_ready, rd0_ready, rd1_ready, sram_web, sram_reb, rsp_valid});
         n_fail++;
      end
      step();
      step();
      n_chk++;
      if ({wr0_ready, wr1_ready, rd0_ready, rd1_ready, sram_web, sram_reb, rsp_valid} !== 7'b0) begin
         $display("FAIL reset_held: got %b expected 0000000",
                  {wr0_ready, wr1_ready, rd0_ready, rd1_ready, sram_web, sram_reb, rsp_valid});
         n_fail++;
      end

      // First grant right after release, favouring client 0 on both ports.
      RST = 1'b0;
      #2;
      n_chk++;
      if ({wr0_ready, wr1_ready, rd0_ready, rd1_ready} !== 4'b1010) begin
         $display("FAIL reset_first_grant: got %b expected 1010",
                  {wr0_ready, wr1_ready, rd0_ready, rd1_ready});
         n_fail++;
      end
      step();
      clear_inputs();
      n_chk++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL reset_pre_rsp_valid: got %b expected 1", rsp_valid);
         n_fail++;
      end

      // Asynchronous: rsp_valid must drop without waiting for an edge.
      RST = 1'b1;
      #1;
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL reset_async_drop: got %b expected 0", rsp_valid);
         n_fail++;
      end
      step();
      RST = 1'b0;

      // Reset lands between a read's acceptance and its response edge.
      rd1_valid = 1; rd1_addr = 8'd2;
      #2;
      n_chk++;
      if (rd1_ready !== 1'b1) begin
         $display("FAIL reset_midread_accept: got %b expected 1", rd1_ready);
         n_fail++;
      end
      #2;
      RST = 1'b1;
      #1;
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL reset_midread_immediate: got %b expected 0", rsp_valid);
         n_fail++;
      end
      @(posedge CLK);
      #2;
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL reset_midread_dropped: got %b expected 0", rsp_valid);
         n_fail++;
      end
      RST = 1'b0;
      wr0_valid = 1; wr0_addr = 8'd3; wr1_valid = 1; wr1_addr = 8'd4;
      rd0_valid = 1; rd0_addr = 8'd1; rd1_valid = 1; rd1_addr = 8'd2;
      #2;
      n_chk++;
      if ({wr0_ready, wr1_ready, rd0_ready, rd1_ready} !== 4'b1010) begin
         $display("FAIL reset_favour_client0: got %b expected 1010",
                  {wr0_ready, wr1_ready, rd0_ready, rd1_ready});
         n_fail++;
      end
      clear_inputs();
      step();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_round_robin();
      logic exp_id;
      do_reset();
      wr0_valid = 1; wr0_addr = 8'd10; wr0_data = 32'hA0; wr0_mask = '1;
      wr1_valid = 1; wr1_addr = 8'd11; wr1_data = 32'hB1; wr1_mask = '1;
      rd0_valid = 1; rd0_addr = 8'd20;
      rd1_valid = 1; rd1_addr = 8'd21;
      for (int i = 0; i < 4; i++) begin
         exp_id = ((i % 2) == 1);
         #2;
         n_chk++;
         if ({wr0_ready, wr1_ready} !== {~exp_id, exp_id}) begin
            $display("FAIL rr_wr_grant[%0d]: got %b expected %b", i,
                     {wr0_ready, wr1_ready}, {~exp_id, exp_id});
            n_fail++;
         end
         n_chk++;
         if (sram_aa !== (exp_id ? 8'd11 : 8'd10)) begin
            $display("FAIL rr_wr_addr[%0d]: got %0d expected %0d", i, sram_aa,
                     exp_id ? 11 : 10);
            n_fail++;
         end
         n_chk++;
         if ({rd0_ready, rd1_ready} !== {~exp_id, exp_id}) begin
            $display("FAIL rr_rd_grant[%0d]: got %b expected %b", i,
                     {rd0_ready, rd1_ready}, {~exp_id, exp_id});
            n_fail++;
         end
         n_chk++;
         if (sram_ab !== (exp_id ? 8'd21 : 8'd20)) begin
            $display("FAIL rr_rd_addr[%0d]: got %0d expected %0d", i, sram_ab,
                     exp_id ? 21 : 20);
            n_fail++;
         end
         if (i > 0) begin
            n_chk++;
            if ({rsp_valid, rsp_id} !== {1'b1, ~exp_id}) begin
               $display("FAIL rr_rsp_id[%0d]: got %b expected %b", i,
                        {rsp_valid, rsp_id}, {1'b1, ~exp_id});
               n_fail++;
            end
         end
         step();
      end
      clear_inputs();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_basic_rw();
      do_reset();
      wr0_valid = 1; wr0_addr = 8'd5; wr0_data = 32'hDEADBEEF; wr0_mask = '1;
      #2;
      n_chk++;
      if ({wr0_ready, sram_web, sram_aa, sram_d} !== {1'b1, 1'b1, 8'd5, 32'hDEADBEEF}) begin
         $display("FAIL basic_write: got ready=%b web=%b aa=%0d d=%h expected 1 1 5 deadbeef",
                  wr0_ready, sram_web, sram_aa, sram_d);
         n_fail++;
      end
      step();
      clear_inputs();
      rd1_valid = 1; rd1_addr = 8'd5;
      #2;
      n_chk++;
      if ({rd1_ready, rd0_ready, sram_reb, sram_ab} !== {1'b1, 1'b0, 1'b1, 8'd5}) begin
         $display("FAIL basic_read_issue: got rd1=%b rd0=%b reb=%b ab=%0d expected 1 0 1 5",
                  rd1_ready, rd0_ready, sram_reb, sram_ab);
         n_fail++;
      end
      step();
      clear_inputs();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
         $display("FAIL basic_rsp: got v=%b id=%b data=%h expected 1 1 deadbeef",
                  rsp_valid, rsp_id, rsp_data);
         n_fail++;
      end
      step();
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL basic_rsp_single: got %b expected 0", rsp_valid);
         n_fail++;
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_masked_write();
      do_reset();
      wr1_valid = 1; wr1_addr = 8'd3; wr1_data = 32'hFFFFFFFF; wr1_mask = '1;
      step();
      wr1_data = 32'h00000000; wr1_mask = 32'h0000FFFF;
      #2;
      n_chk++;
      if ({wr1_ready, sram_bweb} !== {1'b1, 32'h0000FFFF}) begin
         $display("FAIL mask_write_port: got ready=%b bweb=%h expected 1 0000ffff",
                  wr1_ready, sram_bweb);
         n_fail++;
      end
      step();
      clear_inputs();
      rd0_valid = 1; rd0_addr = 8'd3;
      step();
      clear_inputs();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hFFFF0000}) begin
         $display("FAIL mask_read: got v=%b id=%b data=%h expected 1 0 ffff0000",
                  rsp_valid, rsp_id, rsp_data);
         n_fail++;
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_conflict();
      do_reset();
      wr0_valid = 1; wr0_addr = 8'd7; wr0_data = 32'h11; wr0_mask = '1;
      rd0_valid = 1; rd0_addr = 8'd7;
      #2;
      n_chk++;
      if ({wr0_ready, rd0_ready, sram_reb} !== 3'b100) begin
         $display("FAIL conflict_stall: got wr0=%b rd0=%b reb=%b expected 1 0 0",
                  wr0_ready, rd0_ready, sram_reb);
         n_fail++;
      end
      step();
      wr0_valid = 0;
      #2;
      n_chk++;
      if ({rd0_ready, sram_reb, sram_ab, rsp_valid} !== {1'b1, 1'b1, 8'd7, 1'b0}) begin
         $display("FAIL conflict_retry: got rd0=%b reb=%b ab=%0d rspv=%b expected 1 1 7 0",
                  rd0_ready, sram_reb, sram_ab, rsp_valid);
         n_fail++;
      end
      step();
      clear_inputs();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h11}) begin
         $display("FAIL conflict_rsp: got v=%b id=%b data=%h expected 1 0 00000011",
                  rsp_valid, rsp_id, rsp_data);
         n_fail++;
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_starvation();
      do_reset();
      wr0_valid = 1; wr0_addr = 8'd7; wr0_data = 32'h22; wr0_mask = '1;
      wr1_valid = 1; wr1_addr = 8'd9; wr1_data = 32'h99; wr1_mask = '1;
      rd0_valid = 1; rd0_addr = 8'd7;
      #2;
      n_chk++;
      if ({wr0_ready, wr1_ready, rd0_ready, sram_reb} !== 4'b1000) begin
         $display("FAIL starve_cycle1: got wr0=%b wr1=%b rd0=%b reb=%b expected 1 0 0 0",
                  wr0_ready, wr1_ready, rd0_ready, sram_reb);
         n_fail++;
      end
      step();
      #2;
      n_chk++;
      if ({wr0_ready, wr1_ready, sram_aa} !== {1'b0, 1'b1, 8'd9}) begin
         $display("FAIL starve_cycle2_write: got wr0=%b wr1=%b aa=%0d expected 0 1 9",
                  wr0_ready, wr1_ready, sram_aa);
         n_fail++;
      end
      n_chk++;
      if ({rd0_ready, sram_reb, sram_ab} !== {1'b1, 1'b1, 8'd7}) begin
         $display("FAIL starve_cycle2_read: got rd0=%b reb=%b ab=%0d expected 1 1 7",
                  rd0_ready, sram_reb, sram_ab);
         n_fail++;
      end
      step();
      rd0_valid = 0; wr1_valid = 0;
      #2;
      n_chk++;
      if ({rsp_valid, rsp_data} !== {1'b1, 32'h22}) begin
         $display("FAIL starve_rsp: got v=%b data=%h expected 1 00000022", rsp_valid, rsp_data);
         n_fail++;
      end
      n_chk++;
      if (wr0_ready !== 1'b1) begin
         $display("FAIL starve_prio_cleared: got wr0=%b expected 1", wr0_ready);
         n_fail++;
      end
      step();
      clear_inputs();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int a = 0; a < (1 << DW); a++) mem[a] = '0;
      sram_q = '0;
      clear_inputs();
      RST = 1'b1;
      step();
      test_reset();
      test_round_robin();
      test_basic_rw();
      test_masked_write();
      test_conflict();
      test_starvation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dpsram_arbiter.md
# dpsram_arbiter

Arbiter/sequencer in front of one `dualportSRAM` instance. It shares the SRAM's single write port between two write clients and its single read port between two read clients, using round-robin arbitration. It enforces the SRAM rule that the read and write addresses must differ in the same cycle, and returns read data tagged with the client id. It sits between the requesting pipeline stages and the SRAM macro wrapper.

## Interface
Parameters:
- `BITWIDTH`, default 32: data word width; also the width of the bit-enable mask.
- `DEPTH`, default 8: address width; the SRAM holds 2**DEPTH words.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset. The top level drives the SRAM's `RSTN` from `~RST`.
- `wr0_valid` / `wr1_valid`  in  1  write request.
- `wr0_ready` / `wr1_ready`  out  1  write accepted this cycle (combinational).
- `wr0_addr` / `wr1_addr`  in  DEPTH  write address.
- `wr0_data` / `wr1_data`  in  BITWIDTH  write data.
- `wr0_mask` / `wr1_mask`  in  BITWIDTH  per-bit write enable; 1 = write this bit.
- `rd0_valid` / `rd1_valid`  in  1  read request.
- `rd0_ready` / `rd1_ready`  out  1  read accepted this cycle (combinational).
- `rd0_addr` / `rd1_addr`  in  DEPTH  read address.
- `rsp_valid`  out  1  read data valid (registered).
- `rsp_id`  out  1  which read client owns `rsp_data` (registered).
- `rsp_data`  out  BITWIDTH  read data; passthrough of `sram_q`.
- `sram_web`, `sram_aa`, `sram_d`, `sram_bweb`  out  1/DEPTH/BITWIDTH/BITWIDTH  SRAM write port.
- `sram_reb`, `sram_ab`  out  1/DEPTH  SRAM read port.
- `sram_q`  in  BITWIDTH  SRAM read data.

## Operation
State: `wr_ptr` (1b), `rd_ptr` (1b), `rd_prio` (1b), `prio_addr` (DEPTH), `rsp_valid`, `rsp_id`.

Write arbitration, combinational:
- Eligible writers are those with `wrK_valid=1`, minus any writer excluded by the priority rule below.
- If both are eligible, grant client `wr_ptr`. Otherwise grant the single eligible client.
- The grant drives `wrK_ready=1`, `sram_web=1`, and `sram_aa`/`sram_d`/`sram_bweb` from the winner.
- With no grant: `sram_web=0` and `sram_aa`/`sram_d`/`sram_bweb` = 0.
- On a grant to client k, `wr_ptr <= ~k` at the clock edge.

Read arbitration, combinational:
- The candidate is chosen by the same round-robin rule using `rd_ptr`.
- Conflict: the candidate address equals `sram_aa` while `sram_web=1`. On conflict:
  - no read is issued: `sram_reb=0` and both `rdK_ready=0`;
  - `rd_ptr` is unchanged;
  - next state `rd_prio <= 1` and `prio_addr <=` the candidate address.
- No conflict: `sram_reb=1`, `sram_ab` = candidate address, `rdK_ready=1` for the winner, and `rd_ptr <= ~k`.

Priority rule, while `rd_prio=1`:
- Any writer whose address equals `prio_addr` is ineligible; its `wrK_ready=0`.
- A non-matching writer may still be granted.
- `rd_prio` clears on the edge after any read is issued.
- Result: a blocked read waits at most 1 cycle (starvation freedom).

Response path:
- `rsp_valid <= sram_reb`.
- `rsp_id <=` the id of the granted read client.
- `rsp_data = sram_q`.
- There is no backpressure on responses; the consumer must accept whenever `rsp_valid=1`.

Requirements on clients:
- `wrK_*` and `rdK_*` must hold stable while valid and not ready.
- The arbiter does not check or reorder requests across clients beyond the rules above.

## Timing
- Write accepted in cycle N is committed at the end of N. It is visible to a read issued in N+1 or later.
- Read accepted in cycle N: `rsp_valid=1` and data in N+1. Latency is 1 cycle.
- Throughput: 1 write and 1 read per cycle when there is no conflict.
- Simultaneous read and write to the same address: the write wins in cycle N. The read is issued in N+1 and returns the new data in N+2.
- Reset, asynchronous: all state is forced immediately.
  - `wr_ptr=0`, `rd_ptr=0`, `rd_prio=0`, `prio_addr=0`, `rsp_valid=0`, `rsp_id=0`.
  - Any in-flight response is dropped.
  - While `RST=1`, all `*_ready=0`, `sram_web=0` and `sram_reb=0`.
  - The first grant happens in the first cycle after `RST` deasserts.

## Test plan
- **Reset:** assert `RST` mid-read (accepted in N, `RST` rises before N+1 edge) -> `rsp_valid` 0 immediately, stays 0; after release, `wr_ptr`/`rd_ptr` favour client 0.
- **Round-robin:** `wr0` and `wr1` both continuously valid for 4 cycles -> grants alternate 0,1,0,1. The same holds for reads.
- **Basic write/read:** write 0xDEADBEEF to addr 5 (mask all ones), then `rd1` reads addr 5 the next cycle -> `rsp_valid` one cycle later, `rsp_id=1`, `rsp_data=0xDEADBEEF`.
- **Masked write:** write 0xFFFFFFFF to addr 3, then write 0x00000000 with mask 0x0000FFFF -> read of addr 3 returns 0xFFFF0000.
- **Conflict:** `wr0` to addr 7 (data 0x11) and `rd0` to addr 7 in the same cycle -> the read stalls 1 cycle, the write commits, and `rsp_data=0x11` two cycles after the request.
- **Starvation guard:** `wr0` keeps writing addr 7 every cycle while `rd0` requests addr 7 -> the read is issued in the 2nd cycle with `wr0_ready=0` there. Meanwhile `wr1` writing addr 9 is still granted in that cycle.
